// File: rtl/core_dispatch_scoreboard_pkg.sv
// Shared types for the dispatch scoreboard.
//   reg_num     : 4-bit architectural register index
//   hword       : 16-bit per-register mask
//   sb_entry    : one in-flight writeback record {valid, rd}
//   insn_decode : decoded instruction as seen in a dispatch slot
package core_dispatch_scoreboard_pkg;

  localparam int unsigned NUM_REGS = 16;

  typedef logic [3:0]          reg_num;
  typedef logic [NUM_REGS-1:0] hword;

  typedef struct packed {
    logic   valid;
    reg_num rd;
  } sb_entry;

  typedef struct packed {
    logic execute;
  } insn_ctrl;

  typedef struct packed {
    logic   writeback;
    logic   uses_ra;
    logic   uses_rb;
    reg_num ra;
    reg_num rb;
    reg_num rd;
  } insn_data;

  typedef struct packed {
    insn_ctrl ctrl;
    insn_data data;
  } insn_decode;

  function automatic hword onehot(input reg_num n);
    hword v;
    v    = '0;
    v[n] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/core_dispatch_scoreboard_lane.sv
// One ALU lane of the dispatch scoreboard: a shift pipeline of ALU_STAGES
// {valid, rd} records plus the OR-reduced pending-write mask.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_stall        : hold every stage this cycle
//   i_flush        : clear every record at the edge (beats stall and push)
//   i_push, i_rd   : record a write to i_rd entering stage 0
//   o_mask         : one-hot OR of rd over valid stages (registered state only)
//   o_wb_valid     : last stage retires this cycle (suppressed while stalled)
//   o_wb_rd        : register held by the last stage
module core_dispatch_scoreboard_lane
  import core_dispatch_scoreboard_pkg::*;
#(
  parameter int unsigned ALU_STAGES = 2
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_stall,
  input  logic   i_flush,
  input  logic   i_push,
  input  reg_num i_rd,
  output hword   o_mask,
  output logic   o_wb_valid,
  output reg_num o_wb_rd
);

  sb_entry r_pipe [ALU_STAGES];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < ALU_STAGES; i++) begin
        r_pipe[i] <= '0;
      end
    end else if (i_flush) begin
      for (int unsigned i = 0; i < ALU_STAGES; i++) begin
        r_pipe[i] <= '0;
      end
    end else if (!i_stall) begin
      r_pipe[0] <= i_push ? '{valid: 1'b1, rd: i_rd} : '0;
      for (int unsigned i = 1; i < ALU_STAGES; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  // Mask is decoded purely from registered records, so dispatch/flush/stall
  // never reach it combinationally and the hazard-check loop stays broken.
  always_comb begin
    o_mask = '0;
    for (int unsigned i = 0; i < ALU_STAGES; i++) begin
      if (r_pipe[i].valid) begin
        o_mask = o_mask | onehot(r_pipe[i].rd);
      end
    end
  end

  assign o_wb_valid = r_pipe[ALU_STAGES-1].valid && !i_stall;
  assign o_wb_rd    = r_pipe[ALU_STAGES-1].rd;

endmodule

// File: rtl/core_dispatch_scoreboard.sv
// Dispatch scoreboard: tracks destination registers in flight through the
// two ALU lanes and produces the masks consumed by the dispatch hazard check.
//   clk, rst_n             : clock, async active-low reset
//   cur_a, cur_b           : decoded instructions in dispatch slots A/B
//   dispatch_a, dispatch_b : slot issued this cycle
//   alu_stall              : ALU pipeline frozen this cycle
//   flush                  : discard all in-flight records
//   mask_{a,b}_{ra,rb}     : combinational one-hot source-operand masks
//   mask_alu_a, mask_alu_b : registers with a pending write per lane
//   wb_{a,b}_valid/_rd     : lane retires a write this cycle
module core_dispatch_scoreboard
  import core_dispatch_scoreboard_pkg::*;
#(
  parameter int unsigned ALU_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  insn_decode cur_a,
  input  insn_decode cur_b,
  input  logic       dispatch_a,
  input  logic       dispatch_b,
  input  logic       alu_stall,
  input  logic       flush,
  output hword       mask_a_ra,
  output hword       mask_a_rb,
  output hword       mask_b_ra,
  output hword       mask_b_rb,
  output hword       mask_alu_a,
  output hword       mask_alu_b,
  output logic       wb_a_valid,
  output logic       wb_b_valid,
  output reg_num     wb_a_rd,
  output reg_num     wb_b_rd
);

  if (ALU_STAGES < 1 || ALU_STAGES > 4) begin : g_bad_stages
    $error("core_dispatch_scoreboard: ALU_STAGES must be 1..4");
  end

  logic w_push_a;
  logic w_push_b;

  assign w_push_a = dispatch_a && cur_a.data.writeback;
  assign w_push_b = dispatch_b && cur_b.data.writeback;

  always_comb begin
    mask_a_ra = '0;
    mask_a_rb = '0;
    mask_b_ra = '0;
    mask_b_rb = '0;
    if (cur_a.ctrl.execute) begin
      if (cur_a.data.uses_ra) mask_a_ra = onehot(cur_a.data.ra);
      if (cur_a.data.uses_rb) mask_a_rb = onehot(cur_a.data.rb);
    end
    if (cur_b.ctrl.execute) begin
      if (cur_b.data.uses_ra) mask_b_ra = onehot(cur_b.data.ra);
      if (cur_b.data.uses_rb) mask_b_rb = onehot(cur_b.data.rb);
    end
  end

  core_dispatch_scoreboard_lane #(
    .ALU_STAGES(ALU_STAGES)
  ) u_lane_a (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_stall    (alu_stall),
    .i_flush    (flush),
    .i_push     (w_push_a),
    .i_rd       (cur_a.data.rd),
    .o_mask     (mask_alu_a),
    .o_wb_valid (wb_a_valid),
    .o_wb_rd    (wb_a_rd)
  );

  core_dispatch_scoreboard_lane #(
    .ALU_STAGES(ALU_STAGES)
  ) u_lane_b (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_stall    (alu_stall),
    .i_flush    (flush),
    .i_push     (w_push_b),
    .i_rd       (cur_b.data.rd),
    .o_mask     (mask_alu_b),
    .o_wb_valid (wb_b_valid),
    .o_wb_rd    (wb_b_rd)
  );

  // Issuing into a frozen ALU would silently lose the instruction.
  a_no_dispatch_in_stall : assert property (
    @(posedge clk) disable iff (!rst_n)
      !(alu_stall && (dispatch_a || dispatch_b))
  );

  // A retiring record must still be visible in its lane's pending mask.
  a_wb_a_pending : assert property (
    @(posedge clk) disable iff (!rst_n)
      wb_a_valid |-> mask_alu_a[wb_a_rd]
  );
  a_wb_b_pending : assert property (
    @(posedge clk) disable iff (!rst_n)
      wb_b_valid |-> mask_alu_b[wb_b_rd]
  );

endmodule

// File: tb/tb_core_dispatch_scoreboard.sv
module tb_core_dispatch_scoreboard;
  import core_dispatch_scoreboard_pkg::*;

  logic       clk;
  logic       rst_n;
  insn_decode cur_a, cur_b;
  logic       dispatch_a, dispatch_b, alu_stall, flush;
  hword       mask_a_ra, mask_a_rb, mask_b_ra, mask_b_rb;
  hword       mask_alu_a, mask_alu_b;
  logic       wb_a_valid, wb_b_valid;
  reg_num     wb_a_rd, wb_b_rd;

  int total = 0;
  int bad   = 0;

  core_dispatch_scoreboard #(.ALU_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cur_a      (cur_a),
    .cur_b      (cur_b),
    .dispatch_a (dispatch_a),
    .dispatch_b (dispatch_b),
    .alu_stall  (alu_stall),
    .flush      (flush),
    .mask_a_ra  (mask_a_ra),
    .mask_a_rb  (mask_a_rb),
    .mask_b_ra  (mask_b_ra),
    .mask_b_rb  (mask_b_rb),
    .mask_alu_a (mask_alu_a),
    .mask_alu_b (mask_alu_b),
    .wb_a_valid (wb_a_valid),
    .wb_b_valid (wb_b_valid),
    .wb_a_rd    (wb_a_rd),
    .wb_b_rd    (wb_b_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    insn_decode a;
    insn_decode b;
    hword       e_ara;
    hword       e_arb;
    hword       e_bra;
    hword       e_brb;
  } src_vec_t;

  src_vec_t vecs [4];

  function automatic insn_decode mk(input logic ex, input logic wb, input logic ura,
                                    input logic urb, input reg_num ra, input reg_num rb,
                                    input reg_num rd);
    insn_decode d;
    d.ctrl.execute   = ex;
    d.data.writeback = wb;
    d.data.uses_ra   = ura;
    d.data.uses_rb   = urb;
    d.data.ra        = ra;
    d.data.rb        = rb;
    d.data.rd        = rd;
    return d;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cur_a      = '0;
    cur_b      = '0;
    dispatch_a = 1'b0;
    dispatch_b = 1'b0;
    alu_stall  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic chk_lanes(input string tag, input hword ma, input hword mb,
                           input logic wa, input logic wb);
    chk({tag, " mask_alu_a"}, mask_alu_a, ma);
    chk({tag, " mask_alu_b"}, mask_alu_b, mb);
    chk({tag, " wb_a_valid"}, {15'd0, wb_a_valid}, {15'd0, wa});
    chk({tag, " wb_b_valid"}, {15'd0, wb_b_valid}, {15'd0, wb});
  endtask

  initial begin
    vecs[0] = '{mk(1, 0, 1, 0, 4'd4, 4'd7, 4'd0), mk(0, 1, 1, 1, 4'd1, 4'd2, 4'd0),
                16'h0010, 16'h0000, 16'h0000, 16'h0000};
    vecs[1] = '{mk(1, 1, 1, 1, 4'd0, 4'd15, 4'd1), mk(1, 0, 1, 1, 4'd3, 4'd3, 4'd2),
                16'h0001, 16'h8000, 16'h0008, 16'h0008};
    vecs[2] = '{mk(0, 1, 1, 1, 4'd6, 4'd9, 4'd1), mk(1, 0, 0, 1, 4'd5, 4'd10, 4'd2),
                16'h0000, 16'h0000, 16'h0000, 16'h0400};
    vecs[3] = '{mk(1, 1, 1, 1, 4'd15, 4'd0, 4'd1), mk(1, 1, 1, 1, 4'd15, 4'd0, 4'd2),
                16'h8000, 16'h0001, 16'h8000, 16'h0001};

    idle();
    rst_n = 1'b0;
    #2;
    chk_lanes("reset", 16'h0, 16'h0, 1'b0, 1'b0);
    chk("reset wb_a_rd", {12'd0, wb_a_rd}, 16'h0);
    chk("reset wb_b_rd", {12'd0, wb_b_rd}, 16'h0);
    next();
    rst_n = 1'b1;
    next();

    // Source masks: zero latency from cur_x, no dispatch involved.
    for (int i = 0; i < 4; i++) begin
      cur_a = vecs[i].a;
      cur_b = vecs[i].b;
      #1;
      chk($sformatf("src%0d mask_a_ra", i), mask_a_ra, vecs[i].e_ara);
      chk($sformatf("src%0d mask_a_rb", i), mask_a_rb, vecs[i].e_arb);
      chk($sformatf("src%0d mask_b_ra", i), mask_b_ra, vecs[i].e_bra);
      chk($sformatf("src%0d mask_b_rb", i), mask_b_rb, vecs[i].e_brb);
    end
    idle();
    next();

    // Single writer: A rd=5.
    cur_a = mk(1, 1, 0, 0, 4'd0, 4'd0, 4'd5); dispatch_a = 1'b1;
    next(); idle(); #1;
    chk_lanes("single c1", 16'h0020, 16'h0, 1'b0, 1'b0);
    next(); #1;
    chk_lanes("single c2", 16'h0020, 16'h0, 1'b1, 1'b0);
    chk("single c2 wb_a_rd", {12'd0, wb_a_rd}, 16'd5);
    next(); #1;
    chk_lanes("single c3", 16'h0, 16'h0, 1'b0, 1'b0);

    // WAW across lanes on rd=3.
    next();
    cur_a = mk(1, 1, 0, 0, 4'd0, 4'd0, 4'd3); dispatch_a = 1'b1;
    next(); idle();
    cur_b = mk(1, 1, 0, 0, 4'd0, 4'd0, 4'd3); dispatch_b = 1'b1;
    #1;
    chk_lanes("waw c1", 16'h0008, 16'h0, 1'b0, 1'b0);
    next(); idle(); #1;
    chk_lanes("waw c2", 16'h0008, 16'h0008, 1'b1, 1'b0);
    next(); #1;
    chk_lanes("waw c3", 16'h0, 16'h0008, 1'b0, 1'b1);
    chk("waw c3 wb_b_rd", {12'd0, wb_b_rd}, 16'd3);
    next(); #1;
    chk_lanes("waw c4", 16'h0, 16'h0, 1'b0, 1'b0);

    // Stall in cycles 1-2 extends rd=7 to cycle 4.
    next();
    cur_a = mk(1, 1, 0, 0, 4'd0, 4'd0, 4'd7); dispatch_a = 1'b1;
    next(); idle(); alu_stall = 1'b1; #1;
    chk_lanes("stall c1", 16'h0080, 16'h0, 1'b0, 1'b0);
    next(); #1;
    chk_lanes("stall c2", 16'h0080, 16'h0, 1'b0, 1'b0);
    next(); alu_stall = 1'b0; #1;
    chk_lanes("stall c3", 16'h0080, 16'h0, 1'b0, 1'b0);
    next(); #1;
    chk_lanes("stall c4", 16'h0080, 16'h0, 1'b1, 1'b0);
    next(); #1;
    chk_lanes("stall c5", 16'h0, 16'h0, 1'b0, 1'b0);

    // Stall while the record sits in the last stage suppresses wb.
    cur_b = mk(1, 1, 0, 0, 4'd0, 4'd0, 4'd1); dispatch_b = 1'b1;
    next(); idle();
    next(); alu_stall = 1'b1; #1;
    chk_lanes("wbstall c2", 16'h0, 16'h0002, 1'b0, 1'b0);
    next(); alu_stall = 1'b0; #1;
    chk_lanes("wbstall c3", 16'h0, 16'h0002, 1'b0, 1'b1);
    next(); #1;
    chk_lanes("wbstall c4", 16'h0, 16'h0, 1'b0, 1'b0);

    // Flush mid-flight.
    cur_a = mk(1, 1, 0, 0, 4'd0, 4'd0, 4'd2); dispatch_a = 1'b1;
    cur_b = mk(1, 1, 0, 0, 4'd0, 4'd0, 4'd9); dispatch_b = 1'b1;
    next(); idle(); flush = 1'b1; #1;
    chk_lanes("flush c1", 16'h0004, 16'h0200, 1'b0, 1'b0);
    next(); flush = 1'b0; #1;
    chk_lanes("flush c2", 16'h0, 16'h0, 1'b0, 1'b0);
    next(); #1;
    chk_lanes("flush c3", 16'h0, 16'h0, 1'b0, 1'b0);

    // Flush beats a simultaneous dispatch.
    cur_a = mk(1, 1, 0, 0, 4'd0, 4'd0, 4'd6); dispatch_a = 1'b1; flush = 1'b1;
    next(); idle(); #1;
    chk_lanes("flushdisp c1", 16'h0, 16'h0, 1'b0, 1'b0);

    // Non-writeback dispatch leaves nothing pending.
    cur_a = mk(1, 0, 1, 0, 4'd4, 4'd0, 4'd8); dispatch_a = 1'b1;
    next(); idle(); #1;
    chk_lanes("nowb c1", 16'h0, 16'h0, 1'b0, 1'b0);
    next(); #1;
    chk_lanes("nowb c2", 16'h0, 16'h0, 1'b0, 1'b0);

    // Asynchronous reset mid-operation.
    cur_a = mk(1, 1, 0, 0, 4'd0, 4'd0, 4'd12); dispatch_a = 1'b1;
    cur_b = mk(1, 1, 0, 0, 4'd0, 4'd0, 4'd13); dispatch_b = 1'b1;
    next(); idle();
    next(); #1;
    chk_lanes("prerst c2", 16'h1000, 16'h2000, 1'b1, 1'b1);
    chk("prerst wb_a_rd", {12'd0, wb_a_rd}, 16'd12);
    rst_n = 1'b0; #1;
    chk_lanes("midrst", 16'h0, 16'h0, 1'b0, 1'b0);
    chk("midrst wb_a_rd", {12'd0, wb_a_rd}, 16'h0);
    chk("midrst wb_b_rd", {12'd0, wb_b_rd}, 16'h0);
    next(); rst_n = 1'b1;
    next(); #1;
    chk_lanes("postrst", 16'h0, 16'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_dispatch_scoreboard.md
# core_dispatch_scoreboard

Tracks destination registers in flight through the two ALU execution lanes and produces the per-register write-pending and source-operand masks that the dispatch hazard check consumes. It sits beside the dispatch hazard logic in the dispatch stage. Each cycle it records every dispatched instruction that writes back, ages those records through a fixed-depth model of the ALU pipeline, and retires them. Its outputs feed `mask_alu_a`/`mask_alu_b` and `mask_{a,b}_{ra,rb}` of the hazard check.

## Interface
Parameters:
- `ALU_STAGES`, default 2: cycles from dispatch to ALU writeback; legal range 1–4.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cur_a`, `cur_b`  in  `insn_decode`  decoded instructions in dispatch slots A/B.
- `dispatch_a`, `dispatch_b`  in  1  slot issued this cycle, from the hazard check.
- `alu_stall`  in  1  ALU pipeline frozen this cycle.
- `flush`  in  1  discard all in-flight records (branch redirect).
- `mask_a_ra`, `mask_a_rb`, `mask_b_ra`, `mask_b_rb`  out  `hword`  one-hot source masks.
- `mask_alu_a`, `mask_alu_b`  out  `hword`  registers with a pending write in lane A/B.
- `wb_a_valid`, `wb_b_valid`  out  1  lane retires a write this cycle.
- `wb_a_rd`, `wb_b_rd`  out  `reg_num`  register retired by lane A/B.

## Operation
- Source masks are combinational: `mask_a_ra = cur_a.data.uses_ra ? 1 << cur_a.data.ra : 0`. Same rule for the other three masks. They are 0 when `cur_x.ctrl.execute` is low.
- Each lane is a shift pipeline of `ALU_STAGES` entries. An entry is `{valid, rd}`.
- Entry point: at a rising edge with `dispatch_x && cur_x.data.writeback && !alu_stall && !flush`, stage 0 loads `{1, cur_x.data.rd}`. Otherwise, when not stalled, stage 0 loads `valid=0`.
- Advance: when `!alu_stall`, stage i loads stage i−1. The last stage drops off after its writeback cycle.
- `alu_stall` high: all stages hold, and `dispatch_x` is ignored. Dispatch during a stall is a protocol violation, and a simulation assertion flags it.
- `flush` high: all `valid` bits clear at the edge. `flush` has priority over both stall and dispatch.
- `mask_alu_x` is the OR of one-hot(rd) over all valid stages of lane x, decoded from registered state only.
- `wb_x_valid`/`wb_x_rd` come from the last stage. `wb_x_valid` is forced low while `alu_stall` is high.
- Both lanes writing the same rd (WAW) is legal. The register stays pending until both records retire.
- Reset: all `valid` bits are 0, so `mask_alu_*` is 0, `wb_*_valid` is 0 and `wb_*_rd` is 0. Reset mid-operation discards all records.

## Timing
- Dispatch at edge k (end of cycle k). The mask bit is high in cycles k+1 … k+`ALU_STAGES`.
- `wb_x_valid` is high in cycle k+`ALU_STAGES`. The bit clears in cycle k+`ALU_STAGES`+1.
- Each stalled cycle extends the pending window by one.
- No combinational path from `dispatch_x`, `flush` or `alu_stall` to `mask_alu_x`. This breaks the dispatch→mask loop with the hazard check.
- Source masks have zero latency from `cur_x`.

## Structure
- Add `reg_num` (4-bit register index) and `sb_entry` (`struct packed {logic valid; reg_num rd;}`) to `core/uarch.sv`.
- Sub-module `core_dispatch_scoreboard_lane` holds one lane's shift pipeline and mask OR-reduction. It is instantiated twice.
- The top level holds the source-mask decode and the protocol assertions.

## Test plan
- Reset, then idle: `rst_n` low mid-cycle → all `mask_alu_*` = 0 and `wb_*_valid` = 0 immediately, with no clock edge needed.
- Single writer, `ALU_STAGES`=2: slot A dispatches rd=5 at edge 0 → `mask_alu_a` = 0x0020 in cycles 1–2; `wb_a_valid` = 1 with `wb_a_rd` = 5 in cycle 2; mask = 0 in cycle 3.
- Back-to-back WAW across lanes: A rd=3 at edge 0, B rd=3 at edge 1 → bit 3 is set in `mask_alu_a` cycles 1–2 and in `mask_alu_b` cycles 2–3; the OR is clear at cycle 4.
- Stall: A rd=7 at edge 0, `alu_stall` high in cycles 1–2 → `mask_alu_a` = 0x0080 through cycle 4; `wb_a_valid` is high only in cycle 4.
- Flush mid-flight: A rd=2 and B rd=9 at edge 0, `flush` in cycle 1 → both masks = 0 from cycle 2; no `wb_*_valid` pulse.
- Non-writeback and source masks: `cur_a` with `writeback`=0 dispatched → `mask_alu_a` stays 0. With `uses_rb`=0 and `ra`=4 → `mask_a_ra` = 0x0010 and `mask_a_rb` = 0.
